dcache_ctl: RTL and testbench

//  Direct-mapped, write-through, no-write-allocate data cache with a one-word line.

---
 rtl/dcache_ctl.sv | 143 ++++++++++++++
 tb/tb_dcache_ctl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctl.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Read hits complete in the request cycle; misses and all writes stall until main memory completes.
module dcache_ctl #(
  parameter int unsigned IDX_W = 6,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      cpu_addr,
  input  logic             cpu_read,
  input  logic             cpu_write,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_ready,
  output logic             cpu_hit,
  input  logic             flush,
  output logic [31:0]      mem_addr,
  output logic             mem_read,
  output logic             mem_write,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int unsigned Lines = 2 ** IDX_W;
  localparam int unsigned TagW  = 30 - IDX_W;

  typedef enum logic [1:0] {StIdle, StFill, StWrite} state_e;

  state_e state_q, state_d;

  logic [31:0]      data_q [Lines];
  logic [TagW-1:0]  tag_q  [Lines];
  logic [Lines-1:0] valid_q;
  logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q;

  logic [IDX_W-1:0] idx;
  logic [TagW-1:0]  tag;
  logic             lookup_hit;
  logic             fill_we, wr_hit_we, flush_go, hit_inc, miss_inc;
  logic             unused_addr;

  assign idx         = cpu_addr[IDX_W+1:2];
  assign tag         = cpu_addr[31:IDX_W+2];
  assign lookup_hit  = valid_q[idx] && (tag_q[idx] == tag);
  assign unused_addr = ^cpu_addr[1:0];

  assign mem_addr  = {cpu_addr[31:2], 2'b00};
  assign mem_wdata = cpu_wdata;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_write) begin
          state_d = StWrite;
        end else if (cpu_read && !lookup_hit) begin
          state_d = StFill;
        end
      end
      StFill:  if (mem_ready) state_d = StIdle;
      StWrite: if (mem_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cpu_ready = 1'b0;
    cpu_rdata = data_q[idx];
    cpu_hit   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    fill_we   = 1'b0;
    wr_hit_we = 1'b0;
    flush_go  = 1'b0;
    hit_inc   = 1'b0;
    miss_inc  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cpu_write) begin
          wr_hit_we = lookup_hit;
        end else if (cpu_read) begin
          cpu_hit   = lookup_hit;
          cpu_ready = lookup_hit;
          hit_inc   = lookup_hit;
        end else begin
          flush_go  = flush;
        end
      end
      StFill: begin
        mem_read  = 1'b1;
        cpu_rdata = mem_rdata;
        cpu_ready = mem_ready;
        fill_we   = mem_ready;
        miss_inc  = mem_ready;
      end
      StWrite: begin
        mem_write = 1'b1;
        cpu_ready = mem_ready;
      end
      default: ;
    endcase
  end

  // Data/tag need no reset: a line is only ever read through its valid bit.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_q[idx] <= mem_rdata;
      tag_q[idx]  <= tag;
    end else if (wr_hit_we) begin
      data_q[idx] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (flush_go) begin
        valid_q <= '0;
      end else if (fill_we) begin
        valid_q[idx] <= 1'b1;
      end
      if (hit_inc)  hit_cnt_q  <= hit_cnt_q + CNT_W'(1);
      if (miss_inc) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dcache_ctl.sv
// Scoreboard bench for dcache_ctl: a behavioural cache/memory model predicts each response,
// a memory responder plays main memory, and a monitor checks every completed request.
module tb_dcache_ctl;

  localparam int unsigned IDX_W = 6;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned LINES = 2 ** IDX_W;
  localparam int unsigned CMASK = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [31:0]      cpu_addr = '0;
  logic             cpu_read = 1'b0;
  logic             cpu_write = 1'b0;
  logic [31:0]      cpu_wdata = '0;
  logic [31:0]      cpu_rdata;
  logic             cpu_ready;
  logic             cpu_hit;
  logic             flush = 1'b0;
  logic [31:0]      mem_addr;
  logic             mem_read;
  logic             mem_write;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata = '0;
  logic             mem_ready = 1'b0;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;

  always #5 clk = ~clk;

  dcache_ctl #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_read  (cpu_read),
    .cpu_write (cpu_write),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .cpu_hit   (cpu_hit),
    .flush     (flush),
    .mem_addr  (mem_addr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  typedef struct {
    bit          wr;
    bit          hit;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] main_mem[int unsigned];
  logic [31:0] ref_mem[int unsigned];
  bit          ref_valid[LINES];
  int unsigned ref_line[LINES];
  int unsigned hits = 0;
  int unsigned misses = 0;
  int          lat_override = 2;

  function automatic logic [31:0] init_word(int unsigned w);
    return (w * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] main_rd(int unsigned w);
    return main_mem.exists(w) ? main_mem[w] : init_word(w);
  endfunction

  function automatic logic [31:0] ref_rd(int unsigned w);
    return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cache as a map from line index to the word address it holds; data always equals memory.
  function automatic bit model_issue(input bit wr, input logic [31:0] addr,
                                     input logic [31:0] wd);
    int unsigned w   = 32'(addr[31:2]);
    int unsigned idx = w % LINES;
    bit          hit = ref_valid[idx] && (ref_line[idx] == w);
    exp_t        e;
    e.wr    = wr;
    e.hit   = hit && !wr;
    e.rdata = ref_rd(w);
    exp_q.push_back(e);
    if (wr) begin
      ref_mem[w] = wd;
    end else if (hit) begin
      hits++;
    end else begin
      misses++;
      ref_valid[idx] = 1'b1;
      ref_line[idx]  = w;
    end
    return hit;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
  endfunction

  task automatic finish_req(input bit exp_fast);
    int n    = 0;
    bit done = 1'b0;
    while (!done && n < 100) begin
      @(negedge clk);
      if (cpu_ready) done = 1'b1;
      else n++;
    end
    if (!done) begin
      errors++;
      $display("FAIL req_timeout: got no cpu_ready expected cpu_ready within 100 cycles");
      exp_q.delete();
    end
    if (exp_fast) check("hit_latency", n, 0);
    @(posedge clk);
    #1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    flush     = 1'b0;
    check("hit_cnt", 32'(hit_cnt), hits & CMASK);
    check("miss_cnt", 32'(miss_cnt), misses & CMASK);
  endtask

  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wd);
    bit hit = model_issue(wr, addr, wd);
    cpu_addr  = addr;
    cpu_wdata = wd;
    cpu_read  = !wr;
    cpu_write = wr;
    finish_req(hit && !wr);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    model_clear();
  endtask

  // Main memory: random (or forced) latency, data valid only with mem_ready.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!reset || !(mem_read || mem_write)) begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        wait_cnt  = (lat_override >= 0) ? lat_override : int'($urandom_range(0, 3));
      end else if (wait_cnt == 0) begin
        mem_ready = 1'b1;
        if (mem_read) mem_rdata = main_rd(32'(mem_addr[31:2]));
        else main_mem[32'(mem_addr[31:2])] = mem_wdata;
      end else begin
        wait_cnt--;
        mem_ready = 1'b0;
        mem_rdata = $urandom;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (mem_read && mem_write) begin
          errors++;
          $display("FAIL mem_excl: got mem_read=1 mem_write=1 expected at most one");
        end
        if (cpu_ready) begin
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ready: got cpu_ready=1 expected no pending request");
          end else begin
            e = exp_q.pop_front();
            if (e.wr) begin
              check("wr_mem_write", 32'(mem_write), 1);
              check("wr_cpu_hit", 32'(cpu_hit), 0);
            end else begin
              check("rd_data", cpu_rdata, e.rdata);
              check("rd_cpu_hit", 32'(cpu_hit), 32'(e.hit));
              check("rd_mem_read", 32'(mem_read), 32'(!e.hit));
            end
          end
        end
      end
    end
  end

  initial begin
    bit hit;
    int k;
    main_mem[32'h40] = 32'hDEADBEEF;
    ref_mem[32'h40]  = 32'hDEADBEEF;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_cpu_ready", 32'(cpu_ready), 0);
    check("rst_mem_read", 32'(mem_read), 0);
    check("rst_mem_write", 32'(mem_write), 0);
    check("rst_hit_cnt", 32'(hit_cnt), 0);
    check("rst_miss_cnt", 32'(miss_cnt), 0);

    // First read after reset must miss and start a fill.
    hit = model_issue(1'b0, 32'h100, 32'h0);
    cpu_addr = 32'h100;
    cpu_read = 1'b1;
    @(negedge clk);
    check("first_ready", 32'(cpu_ready), 0);
    @(posedge clk);
    #1;
    check("first_mem_read", 32'(mem_read), 1);
    finish_req(hit);

    do_req(1'b0, 32'h100, 32'h0);
    do_req(1'b1, 32'h100, 32'h12345678);
    do_req(1'b0, 32'h100, 32'h0);
    do_req(1'b1, 32'h200, 32'hCAFEF00D);
    do_req(1'b0, 32'h100, 32'h0);
    do_req(1'b0, 32'h200, 32'h0);

    // Reset in the third stalled fill cycle aborts the fill.
    lat_override = 5;
    cpu_addr = 32'h300;
    cpu_read = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("abort_mem_read_before", 32'(mem_read), 1);
    reset = 1'b0;
    #1;
    check("abort_mem_read", 32'(mem_read), 0);
    check("abort_cpu_ready", 32'(cpu_ready), 0);
    cpu_read = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    lat_override = 2;
    model_clear();
    hits = 0;
    misses = 0;
    exp_q.delete();
    check("abort_hit_cnt", 32'(hit_cnt), 0);
    check("abort_miss_cnt", 32'(miss_cnt), 0);
    do_req(1'b0, 32'h100, 32'h0);

    do_req(1'b0, 32'h100, 32'h0);
    do_flush();
    do_req(1'b0, 32'h100, 32'h0);

    lat_override = -1;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2) |
          32'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) do_flush();
      hit = model_issue($urandom_range(0, 2) == 0, a, $urandom);
      cpu_addr  = a;
      cpu_wdata = ref_rd(32'(a[31:2]));
      cpu_read  = !exp_q[exp_q.size()-1].wr;
      cpu_write = exp_q[exp_q.size()-1].wr;
      flush     = ($urandom_range(0, 7) == 0);
      finish_req(hit && cpu_read);
    end

    // Drive miss_cnt to its maximum, then two more misses must wrap it.
    lat_override = 1;
    do_flush();
    k = 0;
    while ((misses & CMASK) != CMASK) begin
      do_req(1'b0, 32'h1000_0000 + (32'(k) << 8), 32'h0);
      k++;
    end
    do_req(1'b0, 32'h1000_0000 + (32'(k) << 8), 32'h0);
    check("wrap_to_0", 32'(miss_cnt), 0);
    do_req(1'b0, 32'h1000_0000 + (32'(k + 1) << 8), 32'h0);
    check("wrap_to_1", 32'(miss_cnt), 1);

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending: got %0d outstanding expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
